move_cmd_sequencer: RTL and testbench
=====================================

MOVE_CMD_SEQUENCER -- requirements
Module: move_cmd_sequencer

Interface
REQ-001 Parameter NUM_MOVES, default 24, number of tour moves replayed per tour.
REQ-002 clk  input  1  system clock; one clock domain, all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start_tour  input  1  one-cycle pulse from the tour solver's done; starts replay.
REQ-005 move  input  8  one-hot move read from the tour solver at address mv_indx.
REQ-006 mv_indx  output  5  index of the move currently being replayed.
REQ-007 cmd_UART  input  16  command from the UART wrapper, used in pass-through mode.
REQ-008 cmd_rdy_UART  input  1  UART command valid.
REQ-009 clr_cmd_rdy_UART  output  1  acknowledge to the UART wrapper.
REQ-010 cmd  output  16  command to the command processor: [15:12] opcode, [11:4] heading, [3:0] squares.
REQ-011 cmd_rdy  output  1  command valid to the command processor.
REQ-012 clr_cmd_rdy  input  1  command processor accepted cmd.
REQ-013 send_resp  input  1  command processor finished executing the command.

Function
REQ-014 States SHALL be IDLE, VERT, WAIT_V, HORZ, WAIT_H.
REQ-015 IDLE (pass-through): cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, all combinational.
REQ-016 Outside IDLE: clr_cmd_rdy_UART=0 and cmd_UART/cmd_rdy_UART are ignored.
REQ-017 IDLE with start_tour: next state VERT, mv_indx<=0.
REQ-018 VERT: cmd_rdy=1, cmd = vertical component of move. clr_cmd_rdy goes to WAIT_V.
REQ-019 WAIT_V: cmd_rdy=0. send_resp goes to HORZ.
REQ-020 HORZ: cmd_rdy=1, cmd = horizontal component of move. clr_cmd_rdy goes to WAIT_H.
REQ-021 WAIT_H: cmd_rdy=0. On send_resp:
- if mv_indx==NUM_MOVES-1: go to IDLE, mv_indx<=0.
- else: mv_indx<=mv_indx+1, go to VERT.
REQ-022 cmd SHALL be held stable while cmd_rdy=1. move must be stable one cycle after mv_indx changes, which the upstream combinational read guarantees.
REQ-023 Opcodes: vertical component uses MOVE=4'h2. Horizontal component uses MOVE_FANFARE=4'h3.
REQ-024 Headings: north (+y)=8'h00, west (-x)=8'h3F, south (-y)=8'h7F, east (+x)=8'hBF.
REQ-025 Decode table, move bit -> (dx, dy):
- bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1)
- bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
REQ-026 Squares field = |d| (1 or 2), zero-extended to 4 bits. Heading comes from the sign of d.
REQ-027 Non-one-hot move (including 8'h00): both components have squares=0 and heading north; the handshake proceeds normally.
REQ-028 Events are qualified by state only:
- send_resp in VERT or HORZ is ignored.
- clr_cmd_rdy in WAIT_V or WAIT_H is ignored.
- start_tour outside IDLE is ignored.
REQ-029 Simultaneous clr_cmd_rdy and send_resp in VERT/HORZ: only clr_cmd_rdy acts, and the state moves to WAIT_*.

Reset
REQ-030 On rst_n=0 at posedge clk: state<=IDLE, mv_indx<=0.
REQ-031 After reset, outputs are pass-through: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
REQ-032 Reset mid-tour SHALL abort the replay; no resume.
REQ-033 Before the first clock edge with rst_n=0, outputs are unspecified; no asynchronous path exists.

Structure
REQ-034 Shared package tour_pkg SHALL hold:
- opcode constants MOVE, MOVE_FANFARE
- heading constants NORTH, WEST, SOUTH, EAST
- state enum type seq_state_t
REQ-035 Combinational sub-module move_decode SHALL map move[7:0] to vert_cmd[15:0] and horz_cmd[15:0]. It is instantiated once.
REQ-036 Registered state in the top: state register and mv_indx counter only. All outputs are combinational from state, move, and the UART/processor inputs.

Verification
REQ-037 Reset then IDLE with cmd_UART=16'h2004, cmd_rdy_UART=1, clr_cmd_rdy pulse -> cmd=16'h2004, cmd_rdy=1, clr_cmd_rdy_UART pulses in the same cycle.
REQ-038 start_tour with move=8'h01 -> cmd=16'h2002, cmd_rdy=1. After clr_cmd_rdy then send_resp -> cmd=16'h33F1, cmd_rdy=1.
REQ-039 move=8'h40 -> vertical cmd 16'h27F1, horizontal cmd 16'h3BF2. move=8'h00 -> 16'h2000 and 16'h3000.
REQ-040 Full tour of 24 moves with an auto-responding consumer:
- mv_indx steps 0..23, with 48 cmd_rdy assertions.
- Returns to IDLE with mv_indx=0 after the 48th send_resp.
REQ-041 Event ordering:
- send_resp in VERT before clr_cmd_rdy -> state stays VERT.
- start_tour in WAIT_H -> ignored.
- Simultaneous clr_cmd_rdy+send_resp in HORZ -> WAIT_H only.
REQ-042 rst_n=0 for one cycle in WAIT_V at mv_indx=7 -> next cycle IDLE, mv_indx=0, pass-through active.

Source files
------------

// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour move command sequencer.
package tour_pkg;

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned MOVE_W = 8;
    localparam int unsigned CMD_W  = 16;

    localparam logic [3:0] MOVE         = 4'h2;
    localparam logic [3:0] MOVE_FANFARE = 4'h3;

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] EAST  = 8'hBF;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } seq_state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] heading;
        logic [3:0] squares;
    } cmd_t;

endpackage

// File: rtl/move_cmd_sequencer_if.sv
// Handshake bundle between the sequencer, the UART wrapper, the tour solver and the command processor.
interface move_cmd_sequencer_if;
    import tour_pkg::*;

    logic              start_tour;
    logic [MOVE_W-1:0] move;
    logic [IDX_W-1:0]  mv_indx;
    logic [CMD_W-1:0]  cmd_UART;
    logic              cmd_rdy_UART;
    logic              clr_cmd_rdy_UART;
    logic [CMD_W-1:0]  cmd;
    logic              cmd_rdy;
    logic              clr_cmd_rdy;
    logic              send_resp;

    modport master (
        input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy
    );

    modport slave (
        output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy
    );

endinterface

// File: rtl/move_decode.sv
// Splits a one-hot knight move into a vertical MOVE and a horizontal MOVE_FANFARE command.
module move_decode
    import tour_pkg::*;
(
    input  logic [MOVE_W-1:0] move,
    output logic [CMD_W-1:0]  vert_cmd,
    output logic [CMD_W-1:0]  horz_cmd
);

    cmd_t v;
    cmd_t h;

    // Non-one-hot moves fall through to zero-square north commands.
    always_comb begin
        v = '{opcode: MOVE,         heading: NORTH, squares: 4'd0};
        h = '{opcode: MOVE_FANFARE, heading: NORTH, squares: 4'd0};
        case (move)
            8'h01: begin v.squares = 4'd2; h.heading = WEST; h.squares = 4'd1; end
            8'h02: begin v.squares = 4'd2; h.heading = EAST; h.squares = 4'd1; end
            8'h04: begin v.squares = 4'd1; h.heading = WEST; h.squares = 4'd2; end
            8'h08: begin v.heading = SOUTH; v.squares = 4'd1; h.heading = WEST; h.squares = 4'd2; end
            8'h10: begin v.heading = SOUTH; v.squares = 4'd2; h.heading = WEST; h.squares = 4'd1; end
            8'h20: begin v.heading = SOUTH; v.squares = 4'd2; h.heading = EAST; h.squares = 4'd1; end
            8'h40: begin v.heading = SOUTH; v.squares = 4'd1; h.heading = EAST; h.squares = 4'd2; end
            8'h80: begin v.squares = 4'd1; h.heading = EAST; h.squares = 4'd2; end
            default: ;
        endcase
    end

    assign vert_cmd = v;
    assign horz_cmd = h;

endmodule

// File: rtl/move_cmd_sequencer.sv
// Replays a solved tour as vertical/horizontal command pairs; passes UART commands through when idle.
module move_cmd_sequencer
    import tour_pkg::*;
#(
    parameter int unsigned NUM_MOVES = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    move_cmd_sequencer_if.master  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  mv_indx_q, mv_indx_d;
    logic [CMD_W-1:0]  vert_cmd, horz_cmd;
    logic [CMD_W-1:0]  cmd_c;
    logic              cmd_rdy_c;
    logic              clr_uart_c;

    move_decode u_decode (
        .move     (bus.move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    // Events are only honoured in the state that expects them; clr_cmd_rdy wins over send_resp.
    always_comb begin
        state_d    = state_q;
        mv_indx_d  = mv_indx_q;
        cmd_c      = vert_cmd;
        cmd_rdy_c  = 1'b0;
        clr_uart_c = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_c      = bus.cmd_UART;
                cmd_rdy_c  = bus.cmd_rdy_UART;
                clr_uart_c = bus.clr_cmd_rdy;
                if (bus.start_tour) begin
                    state_d   = VERT;
                    mv_indx_d = '0;
                end
            end
            VERT: begin
                cmd_rdy_c = 1'b1;
                if (bus.clr_cmd_rdy) state_d = WAIT_V;
            end
            WAIT_V: begin
                if (bus.send_resp) state_d = HORZ;
            end
            HORZ: begin
                cmd_c     = horz_cmd;
                cmd_rdy_c = 1'b1;
                if (bus.clr_cmd_rdy) state_d = WAIT_H;
            end
            WAIT_H: begin
                cmd_c = horz_cmd;
                if (bus.send_resp) begin
                    if (mv_indx_q == LAST_IDX) begin
                        state_d   = IDLE;
                        mv_indx_d = '0;
                    end else begin
                        state_d   = VERT;
                        mv_indx_d = mv_indx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd              = cmd_c;
    assign bus.cmd_rdy          = cmd_rdy_c;
    assign bus.clr_cmd_rdy_UART = clr_uart_c;
    assign bus.mv_indx          = mv_indx_q;

endmodule

// File: tb/tb_move_cmd_sequencer.sv
// Directed bench for move_cmd_sequencer: pass-through, decode table, event ordering, full tour, mid-tour reset.
module tb_move_cmd_sequencer;
    import tour_pkg::*;

    localparam int unsigned NUM_MOVES = 24;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    move_cmd_sequencer_if bus();

    logic       use_mem;
    logic [7:0] move_drv;
    logic [7:0] tour_mem [32];
    assign bus.move = use_mem ? tour_mem[bus.mv_indx] : move_drv;

    move_cmd_sequencer #(.NUM_MOVES(NUM_MOVES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Hand-computed commands per move bit (index = bit position).
    logic [15:0] v_tab [8] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                               16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
    logic [15:0] h_tab [8] = '{16'h33F1, 16'h3BF1, 16'h33F2, 16'h33F2,
                               16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};

    int   rdy_rises = 0;
    logic rdy_prev  = 1'b0;
    logic cnt_en    = 1'b0;
    always @(negedge clk) begin
        if (cnt_en && bus.cmd_rdy && !rdy_prev) rdy_rises++;
        rdy_prev = bus.cmd_rdy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start_tour   = 1'b0;
        bus.cmd_UART     = 16'h0000;
        bus.cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy  = 1'b0;
        bus.send_resp    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_pulse();
        bus.start_tour = 1'b1;
        tick();
        bus.start_tour = 1'b0;
    endtask

    task automatic accept();
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
    endtask

    task automatic respond();
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        use_mem  = 1'b0;
        move_drv = 8'h00;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bus.cmd_UART = 16'hABCD;
        #1;
        checks++; if (bus.cmd !== 16'hABCD) begin errors++; $display("FAIL reset_cmd: got %h exp %h", bus.cmd, 16'hABCD); end
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy: got %b exp 0", bus.cmd_rdy); end
        checks++; if (bus.mv_indx !== 5'd0) begin errors++; $display("FAIL reset_mv_indx: got %0d exp 0", bus.mv_indx); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_passthrough();
        bus.cmd_UART     = 16'h2004;
        bus.cmd_rdy_UART = 1'b1;
        bus.clr_cmd_rdy  = 1'b1;
        #1;
        checks++; if (bus.cmd !== 16'h2004) begin errors++; $display("FAIL pt_cmd: got %h exp %h", bus.cmd, 16'h2004); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL pt_cmd_rdy: got %b exp 1", bus.cmd_rdy); end
        checks++; if (bus.clr_cmd_rdy_UART !== 1'b1) begin errors++; $display("FAIL pt_clr_uart: got %b exp 1", bus.clr_cmd_rdy_UART); end
        tick();
        bus.clr_cmd_rdy = 1'b0;
        #1;
        checks++; if (bus.clr_cmd_rdy_UART !== 1'b0) begin errors++; $display("FAIL pt_clr_uart_low: got %b exp 0", bus.clr_cmd_rdy_UART); end
        clear_inputs();
    endtask

    task automatic test_event_ordering();
        do_reset();
        move_drv = 8'h01;
        start_pulse();
        bus.cmd_UART     = 16'hFFFF;
        bus.cmd_rdy_UART = 1'b1;
        bus.clr_cmd_rdy  = 1'b0;
        #1;
        checks++; if (bus.cmd !== 16'h2002) begin errors++; $display("FAIL vert_cmd: got %h exp %h", bus.cmd, 16'h2002); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL vert_cmd_rdy: got %b exp 1", bus.cmd_rdy); end
        checks++; if (bus.mv_indx !== 5'd0) begin errors++; $display("FAIL vert_mv_indx: got %0d exp 0", bus.mv_indx); end
        // UART acknowledge must stay low outside IDLE.
        bus.clr_cmd_rdy = 1'b1;
        #1;
        checks++; if (bus.clr_cmd_rdy_UART !== 1'b0) begin errors++; $display("FAIL vert_clr_uart: got %b exp 0", bus.clr_cmd_rdy_UART); end
        bus.clr_cmd_rdy = 1'b0;
        bus.cmd_rdy_UART = 1'b0;
        respond();
        checks++; if (dut.state_q !== VERT) begin errors++; $display("FAIL resp_in_vert: got %0d exp %0d", dut.state_q, VERT); end
        checks++; if (bus.cmd !== 16'h2002 || bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL vert_hold: got %h/%b exp 2002/1", bus.cmd, bus.cmd_rdy); end
        accept();
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL waitv_cmd_rdy: got %b exp 0", bus.cmd_rdy); end
        accept();
        checks++; if (dut.state_q !== WAIT_V) begin errors++; $display("FAIL clr_in_waitv: got %0d exp %0d", dut.state_q, WAIT_V); end
        respond();
        checks++; if (bus.cmd !== 16'h33F1) begin errors++; $display("FAIL horz_cmd: got %h exp %h", bus.cmd, 16'h33F1); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL horz_cmd_rdy: got %b exp 1", bus.cmd_rdy); end
        bus.clr_cmd_rdy = 1'b1;
        bus.send_resp   = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        checks++; if (dut.state_q !== WAIT_H) begin errors++; $display("FAIL simul_clr_resp: got %0d exp %0d", dut.state_q, WAIT_H); end
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL waith_cmd_rdy: got %b exp 0", bus.cmd_rdy); end
        start_pulse();
        checks++; if (dut.state_q !== WAIT_H || bus.mv_indx !== 5'd0) begin errors++; $display("FAIL start_in_waith: got st=%0d idx=%0d exp st=%0d idx=0", dut.state_q, bus.mv_indx, WAIT_H); end
        respond();
        checks++; if (dut.state_q !== VERT || bus.mv_indx !== 5'd1) begin errors++; $display("FAIL waith_advance: got st=%0d idx=%0d exp st=%0d idx=1", dut.state_q, bus.mv_indx, VERT); end
    endtask

    task automatic test_decode();
        logic [7:0]  mv   [11] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h03, 8'hFF};
        logic [15:0] ev   [11] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1, 16'h27F2, 16'h27F2,
                                   16'h27F1, 16'h2001, 16'h2000, 16'h2000, 16'h2000};
        logic [15:0] eh   [11] = '{16'h33F1, 16'h3BF1, 16'h33F2, 16'h33F2, 16'h33F1, 16'h3BF1,
                                   16'h3BF2, 16'h3BF2, 16'h3000, 16'h3000, 16'h3000};
        for (int i = 0; i < 11; i++) begin
            do_reset();
            move_drv = mv[i];
            start_pulse();
            checks++; if (bus.cmd !== ev[i] || bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL decode_vert[%02h]: got %h/%b exp %h/1", mv[i], bus.cmd, bus.cmd_rdy, ev[i]); end
            accept();
            respond();
            checks++; if (bus.cmd !== eh[i] || bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL decode_horz[%02h]: got %h/%b exp %h/1", mv[i], bus.cmd, bus.cmd_rdy, eh[i]); end
        end
    endtask

    task automatic test_full_tour();
        int k;
        int waitc;
        int bitn;
        logic [15:0] exp;
        do_reset();
        use_mem = 1'b1;
        bus.cmd_UART = 16'h5A5A;
        rdy_rises = 0;
        cnt_en = 1'b1;
        start_pulse();
        for (k = 0; k < 2 * NUM_MOVES; k++) begin
            waitc = 0;
            while (bus.cmd_rdy !== 1'b1 && waitc < 20) begin
                tick();
                waitc++;
            end
            if (waitc >= 20) begin
                checks++; errors++;
                $display("FAIL tour_timeout: cmd %0d got cmd_rdy=%b exp 1", k, bus.cmd_rdy);
                break;
            end
            bitn = ((k / 2) * 3) % 8;
            exp  = (k % 2 == 0) ? v_tab[bitn] : h_tab[bitn];
            checks++; if (bus.mv_indx !== 5'(k / 2)) begin errors++; $display("FAIL tour_idx[%0d]: got %0d exp %0d", k, bus.mv_indx, k / 2); end
            checks++; if (bus.cmd !== exp) begin errors++; $display("FAIL tour_cmd[%0d]: got %h exp %h", k, bus.cmd, exp); end
            tick();
            checks++; if (bus.cmd !== exp || bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL tour_hold[%0d]: got %h/%b exp %h/1", k, bus.cmd, bus.cmd_rdy, exp); end
            accept();
            respond();
        end
        cnt_en = 1'b0;
        checks++; if (rdy_rises !== 48) begin errors++; $display("FAIL tour_rdy_count: got %0d exp 48", rdy_rises); end
        checks++; if (bus.mv_indx !== 5'd0) begin errors++; $display("FAIL tour_end_idx: got %0d exp 0", bus.mv_indx); end
        checks++; if (bus.cmd !== 16'h5A5A || bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL tour_end_pt: got %h/%b exp 5a5a/0", bus.cmd, bus.cmd_rdy); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL tour_end_state: got %0d exp %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_reset_mid_tour();
        do_reset();
        use_mem = 1'b1;
        start_pulse();
        for (int k = 0; k < 14; k++) begin
            accept();
            respond();
        end
        accept();
        checks++; if (dut.state_q !== WAIT_V || bus.mv_indx !== 5'd7) begin errors++; $display("FAIL mid_setup: got st=%0d idx=%0d exp st=%0d idx=7", dut.state_q, bus.mv_indx, WAIT_V); end
        do_reset();
        bus.cmd_UART     = 16'h1234;
        bus.cmd_rdy_UART = 1'b1;
        bus.clr_cmd_rdy  = 1'b1;
        #1;
        checks++; if (bus.mv_indx !== 5'd0) begin errors++; $display("FAIL mid_rst_idx: got %0d exp 0", bus.mv_indx); end
        checks++; if (bus.cmd !== 16'h1234 || bus.cmd_rdy !== 1'b1 || bus.clr_cmd_rdy_UART !== 1'b1) begin errors++; $display("FAIL mid_rst_pt: got %h/%b/%b exp 1234/1/1", bus.cmd, bus.cmd_rdy, bus.clr_cmd_rdy_UART); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d exp %0d", dut.state_q, IDLE); end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tour_mem[i] = 8'h01 << ((i * 3) % 8);
        test_reset();
        test_passthrough();
        test_event_ordering();
        test_decode();
        test_full_tour();
        test_reset_mid_tour();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
